// File: rtl/data_memory_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_memory_responder                                                 |
// | Fixed-latency single-port data memory answering store/fetch requests.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] write_addr,
  input  logic [31:0] write_data,
  input  logic        write_activate,
  input  logic [2:0]  bytes_to_write,
  output logic        write_done,
  input  logic        write_taken,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_activate,
  output logic [31:0] fetched_data,
  output logic        fetch_done,
  input  logic        fetch_taken,
  output logic        access_fault
);

  localparam int         c_aw   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] c_cnt0 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_op_write;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [2:0]  r_size;

  logic [c_aw-1:0] w_idx;
  logic            w_oob;
  logic            w_size_bad;
  logic            w_wr_fault;
  logic            w_fault;
  logic            w_exec;
  logic            w_commit;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_rd_word;
  logic [31:0]     w_rd_shift;

  assign w_idx      = r_addr[c_aw+1:2];
  assign w_oob      = {2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign w_size_bad = !(r_size == 3'd1 || r_size == 3'd2 || r_size == 3'd4);
  assign w_wr_fault = w_oob | w_size_bad
                    | ((r_size == 3'd2) & r_addr[0])
                    | ((r_size == 3'd4) & (r_addr[1:0] != 2'b00));
  assign w_fault    = r_op_write ? w_wr_fault : w_oob;
  assign w_exec     = (r_state == S_WAIT) && (r_cnt == 4'd0);
  // Reset on the commit edge must suppress the store.
  assign w_commit   = !rst && w_exec && r_op_write && !w_wr_fault;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = r_data;
    case (r_size)
      3'd1: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_data[7:0]}};
      end
      3'd2: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_data[15:0]}};
      end
      3'd4: begin
        w_be    = 4'b1111;
        w_wdata = r_data;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = r_data;
      end
    endcase
  end

  generate
    for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (w_commit && w_be[g]) begin
          r_mem[w_idx] <= w_wdata[8*g +: 8];
        end
      end

      assign w_rd_word[8*g +: 8] = r_mem[w_idx];
    end
  endgenerate

  assign w_rd_shift = w_rd_word >> {r_addr[1:0], 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_op_write   <= 1'b0;
      r_addr       <= 32'd0;
      r_data       <= 32'd0;
      r_size       <= 3'd0;
      write_done   <= 1'b0;
      fetch_done   <= 1'b0;
      access_fault <= 1'b0;
      fetched_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (write_activate) begin
            r_op_write <= 1'b1;
            r_addr     <= write_addr;
            r_data     <= write_data;
            r_size     <= bytes_to_write;
            r_cnt      <= c_cnt0;
            r_state    <= S_WAIT;
          end else if (fetch_activate) begin
            r_op_write <= 1'b0;
            r_addr     <= fetch_addr;
            r_cnt      <= c_cnt0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            access_fault <= w_fault;
            if (r_op_write) begin
              write_done <= 1'b1;
            end else begin
              fetch_done   <= 1'b1;
              fetched_data <= w_fault ? 32'd0 : w_rd_shift;
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if ((r_op_write && write_taken) || (!r_op_write && fetch_taken)) begin
            write_done   <= 1'b0;
            fetch_done   <= 1'b0;
            access_fault <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// Directed bench for data_memory_responder with hand-computed expectations.
module tb_data_memory_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] write_addr, write_data, fetch_addr, fetched_data;
  logic        write_activate, write_done, write_taken;
  logic [2:0]  bytes_to_write;
  logic        fetch_activate, fetch_done, fetch_taken, access_fault;

  int checks   = 0;
  int failures = 0;

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .write_addr(write_addr), .write_data(write_data),
    .write_activate(write_activate), .bytes_to_write(bytes_to_write),
    .write_done(write_done), .write_taken(write_taken),
    .fetch_addr(fetch_addr), .fetch_activate(fetch_activate),
    .fetched_data(fetched_data), .fetch_done(fetch_done),
    .fetch_taken(fetch_taken), .access_fault(access_fault)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic write_op(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                          output int lat, output logic flt);
    write_addr = a; write_data = d; bytes_to_write = sz; write_activate = 1'b1;
    @(posedge clk); #1;
    write_activate = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (write_done) begin lat = i; break; end
    end
    flt = access_fault;
    write_taken = 1'b1;
    @(posedge clk); #1;
    write_taken = 1'b0;
  endtask

  task automatic fetch_op(input logic [31:0] a, output logic [31:0] d,
                          output int lat, output logic flt);
    fetch_addr = a; fetch_activate = 1'b1;
    @(posedge clk); #1;
    fetch_activate = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (fetch_done) begin lat = i; break; end
    end
    d = fetched_data; flt = access_fault;
    fetch_taken = 1'b1;
    @(posedge clk); #1;
    fetch_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    write_addr = 0; write_data = 0; write_activate = 0; bytes_to_write = 0; write_taken = 0;
    fetch_addr = 0; fetch_activate = 0; fetch_taken = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (write_done !== 1'b0) begin $display("FAIL reset_write_done got=%b exp=0", write_done); failures++; end
    checks++; if (fetch_done !== 1'b0) begin $display("FAIL reset_fetch_done got=%b exp=0", fetch_done); failures++; end
    checks++; if (access_fault !== 1'b0) begin $display("FAIL reset_fault got=%b exp=0", access_fault); failures++; end
    checks++; if (fetched_data !== 32'h0) begin $display("FAIL reset_data got=%h exp=0", fetched_data); failures++; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store();
    int lat; logic flt; logic [31:0] d;
    write_addr = 32'h10; write_data = 32'hDEADBEEF; bytes_to_write = 3'd4; write_activate = 1'b1;
    @(posedge clk); #1;
    write_activate = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (write_done) begin lat = i; break; end
    end
    checks++; if (lat != LAT) begin $display("FAIL word_latency got=%0d exp=%0d", lat, LAT); failures++; end
    checks++; if (access_fault !== 1'b0) begin $display("FAIL word_fault got=%b exp=0", access_fault); failures++; end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (write_done !== 1'b1) begin $display("FAIL word_done_hold cyc=%0d got=%b exp=1", c, write_done); failures++; end
    end
    write_taken = 1'b1;
    @(posedge clk); #1;
    write_taken = 1'b0;
    checks++; if (write_done !== 1'b0) begin $display("FAIL word_done_clear got=%b exp=0", write_done); failures++; end
    fetch_op(32'h10, d, lat, flt);
    checks++; if (d !== 32'hDEADBEEF) begin $display("FAIL word_readback got=%h exp=deadbeef", d); failures++; end
    checks++; if (flt !== 1'b0) begin $display("FAIL word_readback_fault got=%b exp=0", flt); failures++; end
    checks++; if (lat != LAT) begin $display("FAIL fetch_latency got=%0d exp=%0d", lat, LAT); failures++; end
  endtask

  task automatic test_byte_half();
    int lat; logic flt; logic [31:0] d;
    write_op(32'h10, 32'h11223344, 3'd4, lat, flt);
    write_op(32'h13, 32'h000000AB, 3'd1, lat, flt);
    checks++; if (flt !== 1'b0) begin $display("FAIL byte_fault got=%b exp=0", flt); failures++; end
    fetch_op(32'h10, d, lat, flt);
    checks++; if (d !== 32'hAB223344) begin $display("FAIL byte_word got=%h exp=ab223344", d); failures++; end
    fetch_op(32'h13, d, lat, flt);
    checks++; if (d !== 32'h000000AB) begin $display("FAIL byte_shift got=%h exp=000000ab", d); failures++; end
    write_op(32'h12, 32'h0000CAFE, 3'd2, lat, flt);
    checks++; if (flt !== 1'b0) begin $display("FAIL half_fault got=%b exp=0", flt); failures++; end
    fetch_op(32'h10, d, lat, flt);
    checks++; if (d !== 32'hCAFE3344) begin $display("FAIL half_word got=%h exp=cafe3344", d); failures++; end
    fetch_op(32'h11, d, lat, flt);
    checks++; if (d !== 32'h00CAFE33) begin $display("FAIL fetch_off1 got=%h exp=00cafe33", d); failures++; end
  endtask

  task automatic test_faults();
    int lat; logic flt; logic [31:0] d;
    write_op(32'h11, 32'h00009999, 3'd2, lat, flt);
    checks++; if (lat != LAT || flt !== 1'b1) begin $display("FAIL misaligned_half lat=%0d fault=%b exp lat=%0d fault=1", lat, flt, LAT); failures++; end
    write_op(32'h10, 32'h77777777, 3'd3, lat, flt);
    checks++; if (lat != LAT || flt !== 1'b1) begin $display("FAIL bad_size lat=%0d fault=%b exp lat=%0d fault=1", lat, flt, LAT); failures++; end
    write_op(32'h12, 32'h66666666, 3'd4, lat, flt);
    checks++; if (flt !== 1'b1) begin $display("FAIL misaligned_word got=%b exp=1", flt); failures++; end
    write_op(32'(4 * DEPTH), 32'h55555555, 3'd4, lat, flt);
    checks++; if (lat != LAT || flt !== 1'b1) begin $display("FAIL oob_write lat=%0d fault=%b exp lat=%0d fault=1", lat, flt, LAT); failures++; end
    fetch_op(32'h10, d, lat, flt);
    checks++; if (d !== 32'hCAFE3344 || flt !== 1'b0) begin $display("FAIL fault_unchanged got=%h fault=%b exp=cafe3344 fault=0", d, flt); failures++; end
    fetch_op(32'(4 * DEPTH + 4), d, lat, flt);
    checks++; if (d !== 32'h0 || flt !== 1'b1) begin $display("FAIL oob_fetch got=%h fault=%b exp=0 fault=1", d, flt); failures++; end
  endtask

  task automatic test_simultaneous();
    int lat; int flat; logic seen_fetch;
    write_addr = 32'h20; write_data = 32'h00000055; bytes_to_write = 3'd4; write_activate = 1'b1;
    fetch_addr = 32'h20; fetch_activate = 1'b1;
    @(posedge clk); #1;
    lat = 99; seen_fetch = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (fetch_done) seen_fetch = 1'b1;
      if (write_done) begin lat = i; break; end
    end
    checks++; if (lat != LAT || seen_fetch) begin $display("FAIL simul_write_first lat=%0d fetch_seen=%b exp lat=%0d fetch_seen=0", lat, seen_fetch, LAT); failures++; end
    write_taken = 1'b1;
    @(posedge clk); #1;
    write_taken = 1'b0; write_activate = 1'b0;
    flat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (fetch_done) begin flat = i; break; end
    end
    checks++; if (flat != LAT + 1) begin $display("FAIL simul_fetch_delay got=%0d exp=%0d", flat, LAT + 1); failures++; end
    checks++; if (fetched_data !== 32'h00000055) begin $display("FAIL simul_fetch_data got=%h exp=00000055", fetched_data); failures++; end
    fetch_activate = 1'b0; fetch_taken = 1'b1;
    @(posedge clk); #1;
    fetch_taken = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; logic flt; logic [31:0] d;
    write_op(32'h30, 32'h00000000, 3'd4, lat, flt);
    write_addr = 32'h30; write_data = 32'h12345678; bytes_to_write = 3'd4; write_activate = 1'b1;
    @(posedge clk); #1;
    write_activate = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (write_done !== 1'b0 || access_fault !== 1'b0 || fetched_data !== 32'h0)
      begin $display("FAIL rst_mid_outputs done=%b fault=%b data=%h exp 0/0/0", write_done, access_fault, fetched_data); failures++; end
    @(posedge clk); #1;
    checks++; if (write_done !== 1'b0) begin $display("FAIL rst_mid_no_done got=%b exp=0", write_done); failures++; end
    fetch_op(32'h30, d, lat, flt);
    checks++; if (d !== 32'h0 || lat != LAT) begin $display("FAIL rst_mid_not_committed got=%h lat=%0d exp=0 lat=%0d", d, lat, LAT); failures++; end
  endtask

  task automatic test_stall();
    int lat;
    fetch_addr = 32'h10; fetch_activate = 1'b1;
    @(posedge clk); #1;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (fetch_done) begin lat = i; break; end
    end
    checks++; if (lat != LAT) begin $display("FAIL stall_latency got=%0d exp=%0d", lat, LAT); failures++; end
    for (int c = 0; c < 5; c++) begin
      write_taken = c[0];
      fetch_addr = 32'h20;
      @(posedge clk); #1;
      checks++; if (fetch_done !== 1'b1 || fetched_data !== 32'hCAFE3344)
        begin $display("FAIL stall_hold cyc=%0d done=%b data=%h exp done=1 data=cafe3344", c, fetch_done, fetched_data); failures++; end
    end
    write_taken = 1'b0; fetch_taken = 1'b1;
    @(posedge clk); #1;
    fetch_taken = 1'b0; fetch_activate = 1'b0;
    checks++; if (fetch_done !== 1'b0 || access_fault !== 1'b0)
      begin $display("FAIL stall_release done=%b fault=%b exp 0/0", fetch_done, access_fault); failures++; end
    @(posedge clk); #1;
    fetch_taken = 1'b1;
    @(posedge clk); #1;
    fetch_taken = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (fetch_done !== 1'b0 || write_done !== 1'b0)
      begin $display("FAIL stall_idle_taken fdone=%b wdone=%b exp 0/0", fetch_done, write_done); failures++; end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_half();
    test_faults();
    test_simultaneous();
    test_reset_mid();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached exp=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
